// File: rtl/post_normalise32.sv
// post_normalise32
//   Post-addition normalise/pack stage for IEEE-754 single precision.
//   Takes the raw adder mantissa (hidden bit at [MAN_W]), the adder carry-out,
//   the pre-normalised exponent and the sign. It left-shifts the mantissa one
//   bit per enabled cycle until the hidden bit is set, adjusting the exponent,
//   and then packs the result. Zero, overflow to Inf, underflow to a denormal
//   and Inf/NaN passthrough are handled. Rounding is truncation only.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   en         stage enable; when low all state and outputs hold
//   load       start strobe, only sampled in IDLE with en=1
//   sum_in     raw adder mantissa, hidden-bit position [MAN_W]
//   cout_in    adder carry-out
//   exp_in     exponent accompanying sum_in
//   sign_in    result sign
//   result     packed {sign, exp, man}
//   ready      one-cycle pulse when result is updated
//   busy       high while an operation is in flight
//   overflow   last result saturated to Inf
//   underflow  last result denormal (exponent field 0)
module post_normalise32 #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   load,
  input  logic [MAN_W:0]         sum_in,
  input  logic                   cout_in,
  input  logic [EXP_W-1:0]       exp_in,
  input  logic                   sign_in,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   ready,
  output logic                   busy,
  output logic                   overflow,
  output logic                   underflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2
  } state_t;

  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_MAXF = EXP_ONES - EXP_ONE;  // largest finite exponent
  localparam logic [MAN_W:0]   MAN_ZERO = {(MAN_W+1){1'b0}};

  state_t                 state_r, state_s;
  logic [MAN_W:0]         m_r, m_s;
  logic [EXP_W-1:0]       e_r, e_s;
  logic                   sign_r, sign_s;
  logic                   special_r, special_s;
  logic                   ovf_r, ovf_s;
  logic                   zero_r, zero_s;
  logic                   denorm_r, denorm_s;
  logic [EXP_W+MAN_W:0]   result_r, result_s;
  logic                   ready_r, ready_s;
  logic                   overflow_r, overflow_s;
  logic                   underflow_r, underflow_s;

  // State register: everything updates only on enabled edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      m_r         <= MAN_ZERO;
      e_r         <= EXP_ZERO;
      sign_r      <= 1'b0;
      special_r   <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      denorm_r    <= 1'b0;
      result_r    <= {(EXP_W+MAN_W+1){1'b0}};
      ready_r     <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (en) begin
      state_r     <= state_s;
      m_r         <= m_s;
      e_r         <= e_s;
      sign_r      <= sign_s;
      special_r   <= special_s;
      ovf_r       <= ovf_s;
      zero_r      <= zero_s;
      denorm_r    <= denorm_s;
      result_r    <= result_s;
      ready_r     <= ready_s;
      overflow_r  <= overflow_s;
      underflow_r <= underflow_s;
    end else begin
      state_r     <= state_r;
      m_r         <= m_r;
      e_r         <= e_r;
      sign_r      <= sign_r;
      special_r   <= special_r;
      ovf_r       <= ovf_r;
      zero_r      <= zero_r;
      denorm_r    <= denorm_r;
      result_r    <= result_r;
      ready_r     <= ready_r;
      overflow_r  <= overflow_r;
      underflow_r <= underflow_r;
    end
  end

  // Next-state and datapath: capture, normalise one bit per cycle, pack.
  always_comb begin
    state_s     = state_r;
    m_s         = m_r;
    e_s         = e_r;
    sign_s      = sign_r;
    special_s   = special_r;
    ovf_s       = ovf_r;
    zero_s      = zero_r;
    denorm_s    = denorm_r;
    result_s    = result_r;
    ready_s     = 1'b0;
    overflow_s  = overflow_r;
    underflow_s = underflow_r;

    case (state_r)
      IDLE: begin
        if (load) begin
          sign_s      = sign_in;
          special_s   = 1'b0;
          ovf_s       = 1'b0;
          zero_s      = 1'b0;
          denorm_s    = 1'b0;
          overflow_s  = 1'b0;
          underflow_s = 1'b0;
          state_s     = NORM;
          if (exp_in == EXP_ONES) begin
            // Inf/NaN: carried through untouched.
            special_s = 1'b1;
            m_s       = sum_in;
            e_s       = EXP_ONES;
          end else if (cout_in) begin
            // Carry-out: renormalise right by one, dropping the LSB.
            m_s   = {1'b1, sum_in[MAN_W:1]};
            e_s   = exp_in + EXP_ONE;
            ovf_s = (exp_in == EXP_MAXF);
          end else begin
            m_s = sum_in;
            e_s = exp_in;
          end
        end else begin
          state_s = IDLE;
        end
      end

      NORM: begin
        if (special_r || ovf_r) begin
          state_s = PACK;
        end else if (m_r == MAN_ZERO) begin
          zero_s  = 1'b1;
          state_s = PACK;
        end else if (m_r[MAN_W]) begin
          state_s = PACK;
        end else if (e_r <= EXP_ONE) begin
          // Exponent floor reached before the hidden bit: result is denormal.
          denorm_s = 1'b1;
          state_s  = PACK;
        end else begin
          m_s     = {m_r[MAN_W-1:0], 1'b0};
          e_s     = e_r - EXP_ONE;
          state_s = NORM;
        end
      end

      PACK: begin
        ready_s = 1'b1;
        state_s = IDLE;
        if (special_r) begin
          result_s = {sign_r, EXP_ONES, m_r[MAN_W-1:0]};
        end else if (ovf_r) begin
          result_s   = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
          overflow_s = 1'b1;
        end else if (zero_r) begin
          result_s = {sign_r, {(EXP_W+MAN_W){1'b0}}};
        end else if (denorm_r) begin
          result_s    = {sign_r, EXP_ZERO, m_r[MAN_W-1:0]};
          underflow_s = 1'b1;
        end else begin
          result_s = {sign_r, e_r, m_r[MAN_W-1:0]};
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign result    = result_r;
  assign ready     = ready_r;
  assign busy      = (state_r != IDLE);
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule
